// File: rtl/id_operand_stage.sv
// -----------------------------------------------------------------------------
// id_operand_stage
//   Decode-side operand stage placed directly after the GPR file. It drives the
//   register-file read addresses, resolves both source operands (EX/MEM/WB
//   bypass, forced zero for $0), detects load-use hazards and inserts bubbles
//   for them. It owns the ID/EX pipeline register, which has a valid/ready
//   handshake on both sides. A saturating counter records load-use stall
//   cycles for performance debug.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   flush                    kill the ID/EX register contents
//   id_valid / id_ready      upstream handshake
//   id_pc, id_rs, id_rt,
//   id_use_rs, id_use_rt,
//   id_wreg, id_wen,
//   id_is_load               decoded instruction fields
//   rf_rs, rf_rt             register-file read addresses
//   rf_outA, rf_outB         register-file read data (combinational)
//   exf_*, memf_*, wbf_*     bypass sources from EX, MEM and WB
//   ex_valid / ex_ready      downstream handshake
//   ex_pc, ex_srcA, ex_srcB,
//   ex_wreg, ex_wen,
//   ex_is_load               registered payload for EX
//   stall_cnt                saturating load-use stall cycle count
// -----------------------------------------------------------------------------
module id_operand_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_pc,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_wreg,
    input  logic             id_wen,
    input  logic             id_is_load,
    output logic [4:0]       rf_rs,
    output logic [4:0]       rf_rt,
    input  logic [DW-1:0]    rf_outA,
    input  logic [DW-1:0]    rf_outB,
    input  logic             exf_wen,
    input  logic [4:0]       exf_wreg,
    input  logic [DW-1:0]    exf_data,
    input  logic             exf_is_load,
    input  logic             memf_wen,
    input  logic [4:0]       memf_wreg,
    input  logic [DW-1:0]    memf_data,
    input  logic             wbf_wen,
    input  logic [4:0]       wbf_wreg,
    input  logic [DW-1:0]    wbf_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [31:0]      ex_pc,
    output logic [DW-1:0]    ex_srcA,
    output logic [DW-1:0]    ex_srcB,
    output logic [4:0]       ex_wreg,
    output logic             ex_wen,
    output logic             ex_is_load,
    output logic [CNT_W-1:0] stall_cnt
);

    // Bypass priority: youngest producer wins. An EX-stage load has no result
    // yet, so it is skipped here and handled by the interlock instead. WB is
    // needed because the regfile write lands on the same edge as our capture.
    function automatic logic [DW-1:0] resolve(
        input logic [4:0]    idx,
        input logic [DW-1:0] rf_data,
        input logic          f_ex_wen,
        input logic [4:0]    f_ex_wreg,
        input logic [DW-1:0] f_ex_data,
        input logic          f_ex_ld,
        input logic          f_mem_wen,
        input logic [4:0]    f_mem_wreg,
        input logic [DW-1:0] f_mem_data,
        input logic          f_wb_wen,
        input logic [4:0]    f_wb_wreg,
        input logic [DW-1:0] f_wb_data
    );
        if (idx == 5'd0)
            return '0;
        else if (f_ex_wen && f_ex_wreg == idx && !f_ex_ld)
            return f_ex_data;
        else if (f_mem_wen && f_mem_wreg == idx)
            return f_mem_data;
        else if (f_wb_wen && f_wb_wreg == idx)
            return f_wb_data;
        else
            return rf_data;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [DW-1:0]    opa_p0;
    logic [DW-1:0]    opb_p0;
    logic             hazard_p0;
    logic             adv_p0;

    logic             vld_p1;
    logic [31:0]      pc_p1;
    logic [DW-1:0]    srca_p1;
    logic [DW-1:0]    srcb_p1;
    logic [4:0]       wreg_p1;
    logic             wen_p1;
    logic             ld_p1;
    logic [CNT_W-1:0] stall_cnt_q;

    // ---- Stage p0: operand resolution, interlock, handshake (combinational)
    assign rf_rs = id_rs;
    assign rf_rt = id_rt;

    assign opa_p0 = resolve(id_rs, rf_outA, exf_wen, exf_wreg, exf_data, exf_is_load,
                            memf_wen, memf_wreg, memf_data, wbf_wen, wbf_wreg, wbf_data);
    assign opb_p0 = resolve(id_rt, rf_outB, exf_wen, exf_wreg, exf_data, exf_is_load,
                            memf_wen, memf_wreg, memf_data, wbf_wen, wbf_wreg, wbf_data);

    // Only sources the instruction actually reads can stall it; $0 never does.
    assign hazard_p0 = id_valid && exf_wen && exf_is_load && (exf_wreg != 5'd0) &&
                       ((id_use_rs && exf_wreg == id_rs) || (id_use_rt && exf_wreg == id_rt));

    assign adv_p0   = !vld_p1 || ex_ready;
    assign id_ready = adv_p0 && !hazard_p0 && !flush;

    // ---- Stage p1: ID/EX register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            srca_p1     <= '0;
            srcb_p1     <= '0;
            wreg_p1     <= '0;
            wen_p1      <= 1'b0;
            ld_p1       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (adv_p0) begin
                // A hazard loads a bubble; the ID instruction retries next cycle.
                vld_p1  <= id_valid && !hazard_p0;
                pc_p1   <= id_pc;
                srca_p1 <= opa_p0;
                srcb_p1 <= opb_p0;
                wreg_p1 <= id_wreg;
                wen_p1  <= id_wen;
                ld_p1   <= id_is_load;
            end
            if (hazard_p0 && adv_p0 && !flush)
                stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign ex_valid   = vld_p1;
    assign ex_pc      = pc_p1;
    assign ex_srcA    = srca_p1;
    assign ex_srcB    = srcb_p1;
    assign ex_wreg    = wreg_p1;
    assign ex_wen     = wen_p1;
    assign ex_is_load = ld_p1;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_operand_stage
//   Scoreboard bench for id_operand_stage. Every accepted instruction pushes
//   its expected ID/EX payload; while the model says EX holds an instruction
//   the front entry is compared against ex_*, and popped when consumed.
// -----------------------------------------------------------------------------
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt;
    logic [4:0]  id_wreg;
    logic        id_wen, id_is_load;
    logic [4:0]  rf_rs, rf_rt;
    logic [31:0] rf_outA, rf_outB;
    logic        exf_wen;
    logic [4:0]  exf_wreg;
    logic [31:0] exf_data;
    logic        exf_is_load;
    logic        memf_wen;
    logic [4:0]  memf_wreg;
    logic [31:0] memf_data;
    logic        wbf_wen;
    logic [4:0]  wbf_wreg;
    logic [31:0] wbf_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_srcA, ex_srcB;
    logic [4:0]  ex_wreg;
    logic        ex_wen, ex_is_load;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    logic [31:0] regs [32];
    assign rf_outA = regs[rf_rs];
    assign rf_outB = regs[rf_rt];

    id_operand_stage #(.DW(32), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_wen(id_wen), .id_is_load(id_is_load),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_outA(rf_outA), .rf_outB(rf_outB),
        .exf_wen(exf_wen), .exf_wreg(exf_wreg), .exf_data(exf_data), .exf_is_load(exf_is_load),
        .memf_wen(memf_wen), .memf_wreg(memf_wreg), .memf_data(memf_data),
        .wbf_wen(wbf_wen), .wbf_wreg(wbf_wreg), .wbf_data(wbf_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_wreg(ex_wreg),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wreg;
        logic        wen;
        logic        ld;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        mdl_valid;
    logic [31:0] mdl_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hz_m();
        return id_valid && exf_wen && exf_is_load && (exf_wreg != 5'd0) &&
               ((id_use_rs && exf_wreg == id_rs) || (id_use_rt && exf_wreg == id_rt));
    endfunction

    function automatic logic [31:0] res_m(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (exf_wen && exf_wreg == idx && !exf_is_load) return exf_data;
        if (memf_wen && memf_wreg == idx) return memf_data;
        if (wbf_wen && wbf_wreg == idx) return wbf_data;
        return regs[idx];
    endfunction

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] wreg,
                          input logic wen, input logic ld);
        id_valid = 1'b1; id_pc = pc; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt; id_wreg = wreg; id_wen = wen; id_is_load = ld;
    endtask

    task automatic clr_fwd();
        exf_wen = 0; exf_wreg = 0; exf_data = 0; exf_is_load = 0;
        memf_wen = 0; memf_wreg = 0; memf_data = 0;
        wbf_wen = 0; wbf_wreg = 0; wbf_data = 0;
    endtask

    // One clock: check at the negedge, update the model, advance past posedge.
    task automatic tick(input logic [31:0] ea, input logic [31:0] eb);
        logic adv, hz, rdy;
        exp_t e;
        @(negedge clk);
        adv = !mdl_valid || ex_ready;
        hz  = hz_m();
        rdy = adv && !hz && !flush;
        check("id_ready", id_ready, rdy);
        check("ex_valid", ex_valid, mdl_valid);
        check("stall_cnt", stall_cnt, mdl_cnt);
        if (mdl_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb[0];
                check("ex_pc", ex_pc, e.pc);
                check("ex_srcA", ex_srcA, e.a);
                check("ex_srcB", ex_srcB, e.b);
                check("ex_wreg", ex_wreg, e.wreg);
                check("ex_wen", ex_wen, e.wen);
                check("ex_is_load", ex_is_load, e.ld);
                if (ex_ready || flush) void'(sb.pop_front());
            end
        end
        if (id_valid && rdy)
            sb.push_back('{pc: id_pc, a: ea, b: eb, wreg: id_wreg, wen: id_wen, ld: id_is_load});
        if (hz && adv && !flush && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 1;
        if (flush) mdl_valid = 1'b0;
        else if (adv) mdl_valid = id_valid && !hz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000 + i;
        regs[0] = 32'hDEAD;
        regs[1] = 32'd5;
        resetn = 1'b0; flush = 0; ex_ready = 1;
        id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wreg = 0; id_wen = 0; id_is_load = 0;
        clr_fwd();
        mdl_valid = 0; mdl_cnt = 0;

        @(posedge clk); #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_ex_srcA", ex_srcA, 0);
        check("rst_ex_wreg", ex_wreg, 0);
        resetn = 1'b1;

        // $1 from regfile, $0 forced to zero even though the regfile reads 0xDEAD
        set_id(32'h100, 5'd1, 5'd0, 1, 1, 5'd2, 1, 0);
        tick(32'd5, 32'd0);
        set_id(32'h104, 5'd0, 5'd1, 1, 1, 5'd2, 1, 0);
        tick(32'd0, 32'd5);

        // bypass priority EX > MEM > WB
        set_id(32'h108, 5'd3, 5'd5, 1, 1, 5'd7, 1, 0);
        exf_wen = 1; exf_wreg = 3; exf_data = 32'h11;
        memf_wen = 1; memf_wreg = 3; memf_data = 32'h22;
        wbf_wen = 1; wbf_wreg = 3; wbf_data = 32'h33;
        tick(32'h11, 32'hA005);
        exf_wen = 0;
        tick(32'h22, 32'hA005);
        memf_wen = 0;
        tick(32'h33, 32'hA005);
        clr_fwd();

        // EX load to an unused source: no stall, load data not forwarded
        set_id(32'h10C, 5'd6, 5'd0, 0, 1, 5'd8, 0, 1);
        exf_wen = 1; exf_wreg = 6; exf_data = 32'h99; exf_is_load = 1;
        tick(32'hA006, 32'd0);
        // EX load to $0 never stalls
        set_id(32'h110, 5'd0, 5'd0, 1, 1, 5'd8, 0, 0);
        exf_wreg = 0;
        tick(32'd0, 32'd0);
        clr_fwd();

        // load-use on rt: bubble, then retry with MEM bypass
        set_id(32'h114, 5'd2, 5'd4, 1, 1, 5'd9, 1, 0);
        exf_wen = 1; exf_wreg = 4; exf_data = 32'hBAD; exf_is_load = 1;
        tick(32'd0, 32'd0);
        check("stall_after_hazard", stall_cnt, 1);
        check("bubble_ex_valid", ex_valid, 0);
        clr_fwd();
        memf_wen = 1; memf_wreg = 4; memf_data = 32'h77;
        tick(32'hA002, 32'h77);
        clr_fwd();

        // backpressure: EX holds for 3 cycles, then the waiting instruction enters
        set_id(32'h200, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0);
        tick(32'd5, 32'd5);
        set_id(32'h204, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0);
        ex_ready = 0;
        repeat (3) tick(32'hA002, 32'hA003);
        ex_ready = 1;
        tick(32'hA002, 32'hA003);
        check("bp_accept_pc", ex_pc, 32'h204);
        id_valid = 0;
        tick(32'd0, 32'd0);

        // flush coincident with a hazard: no count, nothing enters EX
        set_id(32'h300, 5'd4, 5'd0, 1, 0, 5'd5, 1, 0);
        exf_wen = 1; exf_wreg = 4; exf_is_load = 1; flush = 1;
        tick(32'd0, 32'd0);
        flush = 0;
        clr_fwd();
        check("flush_stall_cnt", stall_cnt, 1);
        check("flush_ex_valid", ex_valid, 0);

        // asynchronous reset in the middle of a cycle
        set_id(32'h400, 5'd1, 5'd0, 1, 0, 5'd6, 1, 0);
        tick(32'd5, 32'd0);
        id_valid = 0;
        check("pre_rst_ex_valid", ex_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_ex_valid", ex_valid, 0);
        check("async_rst_stall_cnt", stall_cnt, 0);
        check("async_rst_ex_pc", ex_pc, 0);
        sb.delete();
        mdl_valid = 0; mdl_cnt = 0;
        @(posedge clk); #1;
        resetn = 1'b1;

        // random traffic with a small register window to provoke bypass/hazards
        for (int n = 0; n < 300; n++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_pc = 32'h1000 + n * 4;
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_use_rs = 1'($urandom_range(0, 1));
            id_use_rt = 1'($urandom_range(0, 1));
            id_wreg = 5'($urandom_range(0, 31));
            id_wen = 1'($urandom_range(0, 1));
            id_is_load = 1'($urandom_range(0, 1));
            exf_wen = 1'($urandom_range(0, 1));
            exf_wreg = 5'($urandom_range(0, 7));
            exf_data = $urandom;
            exf_is_load = ($urandom_range(0, 3) == 0);
            memf_wen = 1'($urandom_range(0, 1));
            memf_wreg = 5'($urandom_range(0, 7));
            memf_data = $urandom;
            wbf_wen = 1'($urandom_range(0, 1));
            wbf_wreg = 5'($urandom_range(0, 7));
            wbf_data = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            tick(res_m(id_rs), res_m(id_rt));
        end
        id_valid = 0; flush = 0; ex_ready = 1;
        clr_fwd();
        repeat (2) tick(32'd0, 32'd0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
